cpu6_alu_slice: RTL and testbench

Slice-serial ALU execute unit for cpu6. It consumes the `alucontrol` code produced by the ALU decoder together with two 32-bit operands, and computes the result over 32/SLICE_W cycles through one SLICE_W-bit datapath. It sits in the execute stage between operand fetch and writeback, with valid/ready handshakes on both sides. It also supplies the zero flag used for branch resolution.

---
 rtl/cpu6_alu_slice.sv | 206 ++++++++++++++++++++
 tb/tb_cpu6_alu_slice.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_alu_slice.sv
// Slice-serial ALU execute unit for cpu6: valid/ready in and out, SLICE_W bits per cycle.
// Define CPU6_ALU_FAST_EN to compute the whole operation in one cycle instead.

`ifndef CPU6_ALUCONTROL_SIZE
`define CPU6_ALUCONTROL_SIZE 3
`endif
`ifndef CPU6_ALUCONTROL_AND
`define CPU6_ALUCONTROL_AND 3'b000
`endif
`ifndef CPU6_ALUCONTROL_OR
`define CPU6_ALUCONTROL_OR 3'b001
`endif
`ifndef CPU6_ALUCONTROL_ADD
`define CPU6_ALUCONTROL_ADD 3'b010
`endif
`ifndef CPU6_ALUCONTROL_XOR
`define CPU6_ALUCONTROL_XOR 3'b100
`endif
`ifndef CPU6_ALUCONTROL_SUB
`define CPU6_ALUCONTROL_SUB 3'b110
`endif
`ifndef CPU6_ALUCONTROL_SLT
`define CPU6_ALUCONTROL_SLT 3'b111
`endif

module cpu6_alu_slice #(
    parameter int SLICE_W = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [`CPU6_ALUCONTROL_SIZE-1:0] alucontrol,
    input  logic [31:0]                      a,
    input  logic [31:0]                      b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      result,
    output logic                             zero
);

    localparam int CW = `CPU6_ALUCONTROL_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_next;
    logic   accept;

    assign in_ready  = ((state == S_IDLE) | ((state == S_DONE) & out_ready)) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

`ifdef CPU6_ALU_FAST_EN

    logic [31:0] fast_sum;
    logic [32:0] fast_diff;
    logic [31:0] fast_value;

    always_comb begin
        fast_sum   = a + b;
        fast_diff  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        fast_value = 32'd0;
        case (alucontrol)
            `CPU6_ALUCONTROL_ADD: fast_value = fast_sum;
            `CPU6_ALUCONTROL_SUB: fast_value = fast_diff[31:0];
            `CPU6_ALUCONTROL_AND: fast_value = a & b;
            `CPU6_ALUCONTROL_OR:  fast_value = a | b;
            `CPU6_ALUCONTROL_XOR: fast_value = a ^ b;
            `CPU6_ALUCONTROL_SLT: fast_value = {31'd0, ~fast_diff[32]};
            default:              fast_value = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_next = S_DONE;
                S_DONE: begin
                    if (accept)         state_next = S_DONE;
                    else if (out_ready) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= 32'd0;
            zero   <= 1'b0;
        end else if (accept) begin
            result <= fast_value;
            zero   <= (fast_value == 32'd0);
        end
    end

`else

    localparam int N    = 32 / SLICE_W;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    logic [31:0]      op_a, op_b, acc, acc_merged, final_value;
    logic [CW-1:0]    op_ctl;
    logic [CNTW-1:0]  cnt;
    logic             carry, last_slice, op_is_sub;
    logic [SLICE_W-1:0] a_sl, b_sl, b_eff, slice_res;
    logic [SLICE_W:0]   slice_sum;
    int               base;

    function automatic logic needs_sub(input logic [CW-1:0] ctl);
        return (ctl == `CPU6_ALUCONTROL_SUB) || (ctl == `CPU6_ALUCONTROL_SLT);
    endfunction

    // One slice of the datapath; acc_merged is the accumulator with this cycle's slice folded in.
    always_comb begin
        base       = int'(cnt) * SLICE_W;
        last_slice = (cnt == CNTW'(N - 1));
        op_is_sub  = needs_sub(op_ctl);
        a_sl       = op_a[base +: SLICE_W];
        b_sl       = op_b[base +: SLICE_W];
        b_eff      = op_is_sub ? ~b_sl : b_sl;
        slice_sum  = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry};
        slice_res  = '0;
        case (op_ctl)
            `CPU6_ALUCONTROL_AND: slice_res = a_sl & b_sl;
            `CPU6_ALUCONTROL_OR:  slice_res = a_sl | b_sl;
            `CPU6_ALUCONTROL_XOR: slice_res = a_sl ^ b_sl;
            default:              slice_res = slice_sum[SLICE_W-1:0];
        endcase
        acc_merged = acc;
        acc_merged[base +: SLICE_W] = slice_res;
        final_value = 32'd0;
        case (op_ctl)
            `CPU6_ALUCONTROL_ADD,
            `CPU6_ALUCONTROL_SUB,
            `CPU6_ALUCONTROL_AND,
            `CPU6_ALUCONTROL_OR,
            `CPU6_ALUCONTROL_XOR: final_value = acc_merged;
            `CPU6_ALUCONTROL_SLT: final_value = {31'd0, ~slice_sum[SLICE_W]};
            default:              final_value = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_next = S_BUSY;
                S_BUSY:  if (last_slice) state_next = S_DONE;
                S_DONE: begin
                    if (accept)         state_next = S_BUSY;
                    else if (out_ready) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // The visible result only moves on the final slice; acc carries the partial work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            op_ctl <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            acc    <= 32'd0;
            result <= 32'd0;
            zero   <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                op_a   <= a;
                op_b   <= b;
                op_ctl <= alucontrol;
                cnt    <= '0;
                carry  <= needs_sub(alucontrol);
            end else if (state == S_BUSY) begin
                acc   <= acc_merged;
                cnt   <= cnt + 1'b1;
                carry <= slice_sum[SLICE_W];
                if (last_slice) begin
                    result <= final_value;
                    zero   <= (final_value == 32'd0);
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_cpu6_alu_slice.sv
// Directed self-checking bench for cpu6_alu_slice at SLICE_W=8.

`ifndef CPU6_ALUCONTROL_SIZE
`define CPU6_ALUCONTROL_SIZE 3
`endif
`ifndef CPU6_ALUCONTROL_AND
`define CPU6_ALUCONTROL_AND 3'b000
`endif
`ifndef CPU6_ALUCONTROL_OR
`define CPU6_ALUCONTROL_OR 3'b001
`endif
`ifndef CPU6_ALUCONTROL_ADD
`define CPU6_ALUCONTROL_ADD 3'b010
`endif
`ifndef CPU6_ALUCONTROL_XOR
`define CPU6_ALUCONTROL_XOR 3'b100
`endif
`ifndef CPU6_ALUCONTROL_SUB
`define CPU6_ALUCONTROL_SUB 3'b110
`endif
`ifndef CPU6_ALUCONTROL_SLT
`define CPU6_ALUCONTROL_SLT 3'b111
`endif

module tb_cpu6_alu_slice;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             flush;
    logic                             in_valid;
    logic                             in_ready;
    logic [`CPU6_ALUCONTROL_SIZE-1:0] alucontrol;
    logic [31:0]                      a, b;
    logic                             out_valid;
    logic                             out_ready;
    logic [31:0]                      result;
    logic                             zero;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cpu6_alu_slice #(.SLICE_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alucontrol(alucontrol),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    // Offer one operation for a single edge; returns 1 ns after that edge.
    task automatic start_op(input logic [`CPU6_ALUCONTROL_SIZE-1:0] ctl, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        alucontrol = ctl; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h55AA55AA; alucontrol = `CPU6_ALUCONTROL_OR;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [`CPU6_ALUCONTROL_SIZE-1:0] ctl,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input logic exp_zero);
        int cyc;
        start_op(ctl, x, y);
        wait_valid(cyc);
        total++;
        if (cyc !== 4) $display("[TB] FAIL %s latency: got %0d need 4", name, cyc);
        else passed++;
        total++;
        if (result !== exp_res || zero !== exp_zero)
            $display("[TB] FAIL %s result: got %h/%b need %h/%b", name, result, zero, exp_res, exp_zero);
        else passed++;
        consume();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL reset_state: got v=%b r=%h z=%b rdy=%b need 0/0/0/1", out_valid, result, zero, in_ready);
        else passed++;
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_flush_ready: got %b need 0", in_ready);
        else passed++;
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith();
        run_op("add_carry", `CPU6_ALUCONTROL_ADD, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0);
        run_op("sub_equal", `CPU6_ALUCONTROL_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1);
        run_op("sub_wrap",  `CPU6_ALUCONTROL_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        run_op("add_full",  `CPU6_ALUCONTROL_ADD, 32'h89ABCDEF, 32'h76543211, 32'h00000000, 1'b1);
    endtask

    task automatic test_slt();
        run_op("slt_lt", `CPU6_ALUCONTROL_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op("slt_gt", `CPU6_ALUCONTROL_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        run_op("slt_eq", `CPU6_ALUCONTROL_SLT, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
    endtask

    task automatic test_logic_and_unknown();
        run_op("or",      `CPU6_ALUCONTROL_OR, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0);
        run_op("unknown", 3'b011,             32'h00000007, 32'h00000009, 32'h00000000, 1'b1);
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(`CPU6_ALUCONTROL_ADD, 32'h00000001, 32'h00000002);
        wait_valid(cyc);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || result !== 32'h00000003 || zero !== 1'b0 || in_ready !== 1'b0)
                $display("[TB] FAIL hold_%0d: got v=%b r=%h z=%b rdy=%b need 1/00000003/0/0", i, out_valid, result, zero, in_ready);
            else passed++;
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        alucontrol = `CPU6_ALUCONTROL_XOR; a = 32'hF0F0F0F0; b = 32'hFFFF0000;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL handoff_ready: got %b need 1", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        wait_valid(cyc);
        total++;
        if (cyc !== 4 || result !== 32'h0F0FF0F0 || zero !== 1'b0)
            $display("[TB] FAIL handoff_xor: got lat=%0d r=%h z=%b need 4/0f0ff0f0/0", cyc, result, zero);
        else passed++;
        consume();
    endtask

    task automatic test_flush();
        int seen;
        start_op(`CPU6_ALUCONTROL_ADD, 32'h00000011, 32'h00000022);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL flush_idle: got rdy=%b v=%b need 1/0", in_ready, out_valid);
        else passed++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) $display("[TB] FAIL flush_no_valid: got %0d valid cycles need 0", seen);
        else passed++;
        run_op("and_after_flush", `CPU6_ALUCONTROL_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0);
    endtask

    task automatic test_async_reset();
        int cyc;
        start_op(`CPU6_ALUCONTROL_ADD, 32'h00000003, 32'h00000004);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0)
            $display("[TB] FAIL areset_busy: got v=%b r=%h z=%b need 0/0/0", out_valid, result, zero);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        start_op(`CPU6_ALUCONTROL_SUB, 32'h00000009, 32'h00000009);
        wait_valid(cyc);
        total++;
        if (out_valid !== 1'b1 || zero !== 1'b1)
            $display("[TB] FAIL pre_reset_done: got v=%b z=%b need 1/1", out_valid, zero);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0)
            $display("[TB] FAIL areset_done: got v=%b r=%h z=%b need 0/0/0", out_valid, result, zero);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        run_op("add_after_reset", `CPU6_ALUCONTROL_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alucontrol = '0; a = '0; b = '0;
        test_reset();
        test_arith();
        test_slt();
        test_logic_and_unknown();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
